// File: rtl/whackamole_pkg.sv
// Shared scan FSM encoding and default parameter values for the capacitive
// touch scanner and its per-channel slice.
package whackamole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHARGE,
    ST_MEASURE,
    ST_EVAL
  } scan_state_t;

  localparam int DEF_NUM_SENSORS   = 9;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_CHARGE_CYCLES = 64;
  localparam int DEF_TIMEOUT       = 4095;
  localparam int DEF_DEBOUNCE      = 3;
  localparam int DEF_CAL_SCANS     = 8;
  localparam int DEF_MARGIN        = 32;

endpackage

// File: rtl/cap_channel_debounce.sv
// One capacitive channel: discharge-time latch, calibration baseline,
// threshold compare and debounced touch state.
module cap_channel_debounce
  import whackamole_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int DEBOUNCE  = DEF_DEBOUNCE,
  parameter int CAL_SCANS = DEF_CAL_SCANS,
  parameter int MARGIN    = DEF_MARGIN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             meas_start,
  input  logic             measuring,
  input  logic             sense,
  input  logic [CNT_W-1:0] count,
  input  logic             eval,
  input  logic             calibrating,
  input  logic             cal_last,
  output logic             done,
  output logic [CNT_W-1:0] raw_count,
  output logic             touched,
  output logic             press_event
);

  localparam int CAL_SHIFT = $clog2(CAL_SCANS);
  localparam int SUM_W     = CNT_W + CAL_SHIFT;
  localparam int THR_W     = CNT_W + 1;
  localparam int DB_W      = $clog2(DEBOUNCE + 1);

  logic             latched;
  logic [CNT_W-1:0] meas_cnt;
  logic [CNT_W-1:0] baseline;
  logic [CNT_W-1:0] threshold;
  logic [THR_W-1:0] thr_sum;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_next;
  logic [DB_W-1:0]  db_cnt;
  logic             raw_hit;

  // Threshold saturates so an all-ones baseline can never be exceeded.
  assign thr_sum   = {1'b0, baseline} + THR_W'(MARGIN);
  assign threshold = thr_sum[CNT_W] ? '1 : thr_sum[CNT_W-1:0];
  assign raw_hit   = meas_cnt > threshold;
  assign sum_next  = sum + SUM_W'(meas_cnt);
  assign done      = latched | ~sense;

  always_ff @(posedge clock) begin
    if (!reset) begin
      latched     <= 1'b0;
      meas_cnt    <= '0;
      raw_count   <= '0;
      baseline    <= '1;
      sum         <= '0;
      db_cnt      <= '0;
      touched     <= 1'b0;
      press_event <= 1'b0;
    end else begin
      press_event <= 1'b0;
      // Preloading TIMEOUT means a channel that never discharges reports it.
      if (meas_start) begin
        latched  <= 1'b0;
        meas_cnt <= CNT_W'(TIMEOUT);
      end else if (measuring && !latched && !sense) begin
        latched  <= 1'b1;
        meas_cnt <= count;
      end
      if (eval) begin
        raw_count <= meas_cnt;
        if (calibrating) begin
          if (cal_last) begin
            baseline <= CNT_W'(sum_next >> CAL_SHIFT);
            sum      <= '0;
          end else begin
            sum <= sum_next;
          end
        end else if (raw_hit == touched) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
          touched     <= ~touched;
          press_event <= ~touched;
          db_cnt      <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cap_sensor_scanner.sv
// Charge/discharge-time capacitive scanner: charges all pads together, times
// each pad's discharge, then debounces per-channel touch decisions.
module cap_sensor_scanner
  import whackamole_pkg::*;
#(
  parameter int NUM_SENSORS   = DEF_NUM_SENSORS,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int CHARGE_CYCLES = DEF_CHARGE_CYCLES,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int DEBOUNCE      = DEF_DEBOUNCE,
  parameter int CAL_SCANS     = DEF_CAL_SCANS,
  parameter int MARGIN        = DEF_MARGIN
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         cal_start,
  input  logic [NUM_SENSORS-1:0]       sense_in,
  output logic                         charge_out,
  output logic [NUM_SENSORS-1:0]       touched,
  output logic [NUM_SENSORS-1:0]       press_event,
  output logic [NUM_SENSORS*CNT_W-1:0] raw_count,
  output logic                         scan_done,
  output logic                         calibrating,
  output logic                         cal_done
);

  localparam int CH_W = $clog2(CHARGE_CYCLES + 1);
  localparam int CS_W = $clog2(CAL_SCANS + 1);

  scan_state_t            state;
  scan_state_t            next_state;
  logic [NUM_SENSORS-1:0] sense_meta;
  logic [NUM_SENSORS-1:0] sense_sync;
  logic [NUM_SENSORS-1:0] chan_done;
  logic [CH_W-1:0]        charge_cnt;
  logic [CNT_W-1:0]       count;
  logic [CS_W-1:0]        cal_scans;
  logic                   cal_pending;
  logic                   cal_req;
  logic                   cal_last;
  logic                   meas_start;
  logic                   measuring;
  logic                   eval;
  logic                   charge_entry;
  logic                   all_done;
  logic                   at_timeout;

  assign all_done   = &chan_done;
  assign at_timeout = count == CNT_W'(TIMEOUT);
  assign cal_last   = cal_scans == CS_W'(CAL_SCANS - 1);
  assign cal_req    = (cal_pending | cal_start) & ~calibrating;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sense_meta <= '0;
      sense_sync <= '0;
    end else begin
      sense_meta <= sense_in;
      sense_sync <= sense_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (enable) next_state = ST_CHARGE;
      ST_CHARGE:  if (charge_cnt == CH_W'(CHARGE_CYCLES - 1)) next_state = ST_MEASURE;
      ST_MEASURE: if (all_done || at_timeout) next_state = ST_EVAL;
      ST_EVAL:    next_state = enable ? ST_CHARGE : ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    charge_out   = state == ST_CHARGE;
    meas_start   = (state == ST_CHARGE) && (next_state == ST_MEASURE);
    measuring    = state == ST_MEASURE;
    eval         = state == ST_EVAL;
    charge_entry = (next_state == ST_CHARGE) && (state != ST_CHARGE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      charge_cnt <= '0;
      count      <= '0;
    end else begin
      charge_cnt <= (state == ST_CHARGE) ? charge_cnt + CH_W'(1) : '0;
      count      <= (measuring && next_state == ST_MEASURE) ? count + CNT_W'(1) : '0;
    end
  end

  // A calibration request waits for the next scan start so every averaged
  // scan is a complete one.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cal_pending <= 1'b0;
      calibrating <= 1'b0;
      cal_scans   <= '0;
      scan_done   <= 1'b0;
      cal_done    <= 1'b0;
    end else begin
      scan_done <= eval;
      cal_done  <= 1'b0;
      if (cal_start && !calibrating) cal_pending <= 1'b1;
      if (charge_entry && cal_req) begin
        calibrating <= 1'b1;
        cal_pending <= 1'b0;
        cal_scans   <= '0;
      end
      if (eval && calibrating) begin
        if (cal_last) begin
          calibrating <= 1'b0;
          cal_done    <= 1'b1;
        end else begin
          cal_scans <= cal_scans + CS_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
    cap_channel_debounce #(
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT),
      .DEBOUNCE  (DEBOUNCE),
      .CAL_SCANS (CAL_SCANS),
      .MARGIN    (MARGIN)
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .meas_start  (meas_start),
      .measuring   (measuring),
      .sense       (sense_sync[i]),
      .count       (count),
      .eval        (eval),
      .calibrating (calibrating),
      .cal_last    (cal_last),
      .done        (chan_done[i]),
      .raw_count   (raw_count[i*CNT_W +: CNT_W]),
      .touched     (touched[i]),
      .press_event (press_event[i])
    );
  end

endmodule

// File: tb/tb_cap_sensor_scanner.sv
// Scoreboard bench for cap_sensor_scanner: a sensor model discharges each pad
// at a chosen count and a reference model predicts every scan's results.
module tb_cap_sensor_scanner;

  localparam int N  = 3;
  localparam int CW = 8;
  localparam int CC = 4;
  localparam int TO = 200;
  localparam int DB = 2;
  localparam int CS = 4;
  localparam int MG = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          cal_start = 1'b0;
  logic [N-1:0]  sense_in = '1;
  logic          charge_out, scan_done, calibrating, cal_done;
  logic [N-1:0]  touched, press_event;
  logic [N*CW-1:0] raw_count;

  typedef struct {
    logic [N-1:0]    touched;
    logic [N-1:0]    press;
    logic [N*CW-1:0] raw;
    logic            cal_done;
    logic            calib;
    int              len;
  } exp_t;

  exp_t            sb[$];
  exp_t            got_e;
  logic [N*CW-1:0] stim_q[$];
  logic [N*CW-1:0] cur_fall = '0;
  logic            prev_charge = 1'b0;
  int              k = -2;
  int              charge_len = 0;
  int              done_cnt = 0;
  int              total = 0;
  int              bad = 0;

  int m_touched[N];
  int m_dc[N];
  int m_base[N];
  int m_sum[N];
  int m_cscan;
  bit m_calib;
  bit m_pend;

  cap_sensor_scanner #(
    .NUM_SENSORS   (N),
    .CNT_W         (CW),
    .CHARGE_CYCLES (CC),
    .TIMEOUT       (TO),
    .DEBOUNCE      (DB),
    .CAL_SCANS     (CS),
    .MARGIN        (MG)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .cal_start   (cal_start),
    .sense_in    (sense_in),
    .charge_out  (charge_out),
    .touched     (touched),
    .press_event (press_event),
    .raw_count   (raw_count),
    .scan_done   (scan_done),
    .calibrating (calibrating),
    .cal_done    (cal_done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_touched[i] = 0;
      m_dc[i]      = 0;
      m_base[i]    = (1 << CW) - 1;
      m_sum[i]     = 0;
    end
    m_cscan = 0;
    m_calib = 1'b0;
    m_pend  = 1'b0;
  endtask

  // Queue one scan: fall counts per channel (0 = never discharges).
  task automatic applyStimulus(input int f0, input int f1, input int f2);
    int   f[N];
    int   cnt[N];
    int   mx;
    int   thr;
    bit   hit;
    exp_t e;
    f[0] = f0; f[1] = f1; f[2] = f2;
    if (m_pend && !m_calib) begin
      m_calib = 1'b1;
      m_cscan = 0;
    end
    m_pend = 1'b0;
    e.press = '0;
    e.cal_done = 1'b0;
    mx = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = (f[i] == 0 || f[i] > TO) ? TO : f[i];
      if (cnt[i] > mx) mx = cnt[i];
      e.raw[i*CW +: CW] = CW'(cnt[i]);
    end
    if (m_calib) begin
      for (int i = 0; i < N; i++) m_sum[i] += cnt[i];
      m_cscan++;
      if (m_cscan == CS) begin
        for (int i = 0; i < N; i++) begin
          m_base[i] = m_sum[i] / CS;
          m_sum[i]  = 0;
        end
        m_calib = 1'b0;
        e.cal_done = 1'b1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        thr = m_base[i] + MG;
        if (thr > (1 << CW) - 1) thr = (1 << CW) - 1;
        hit = cnt[i] > thr;
        if (int'(hit) == m_touched[i]) m_dc[i] = 0;
        else begin
          m_dc[i]++;
          if (m_dc[i] == DB) begin
            m_touched[i] = 1 - m_touched[i];
            m_dc[i] = 0;
            if (m_touched[i] == 1) e.press[i] = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) e.touched[i] = (m_touched[i] != 0);
    e.calib = m_calib;
    e.len   = mx + 2;
    sb.push_back(e);
    stim_q.push_back({8'(f2), 8'(f1), 8'(f0)});
  endtask

  task automatic requestCal();
    @(posedge clock); #1;
    cal_start = 1'b1;
    @(posedge clock); #1;
    cal_start = 1'b0;
    if (!m_calib) m_pend = 1'b1;
  endtask

  // Runs queued scans back to back; enable drops during the last scan's charge.
  task automatic runScans();
    int budget;
    budget = 0;
    enable = 1'b1;
    while (stim_q.size() != 0 && budget < 5000) begin
      @(posedge clock); #1;
      budget++;
    end
    enable = 1'b0;
    while (sb.size() != 0 && budget < 5000) begin
      @(posedge clock); #1;
      budget++;
    end
    if (budget >= 5000) checkOutput("scan_wait_timeout", 64'(sb.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  // Sensor model and scoreboard monitor share one process so k is coherent.
  always @(posedge clock) begin
    #1;
    if (k > -2) k++;
    if (scan_done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) checkOutput("unexpected_scan_done", 64'(scan_done), 64'd0);
      else begin
        got_e = sb.pop_front();
        checkOutput("touched", 64'(touched), 64'(got_e.touched));
        checkOutput("press_event", 64'(press_event), 64'(got_e.press));
        checkOutput("raw_count", 64'(raw_count), 64'(got_e.raw));
        checkOutput("cal_done", 64'(cal_done), 64'(got_e.cal_done));
        checkOutput("calibrating", 64'(calibrating), 64'(got_e.calib));
        checkOutput("meas_len", 64'(k), 64'(got_e.len));
      end
    end else begin
      if (press_event != '0) checkOutput("stray_press", 64'(press_event), 64'd0);
      if (cal_done == 1'b1) checkOutput("stray_cal_done", 64'(cal_done), 64'd0);
    end
    if (charge_out === 1'b1) begin
      if (!prev_charge && stim_q.size() != 0) cur_fall = stim_q.pop_front();
      charge_len++;
      k = -1;
    end else if (prev_charge) begin
      checkOutput("charge_len", 64'(charge_len), 64'(CC));
      charge_len = 0;
    end
    prev_charge = charge_out;
    for (int i = 0; i < N; i++)
      sense_in[i] = (charge_out === 1'b1 || cur_fall[i*CW +: CW] == '0 ||
                     k < int'(cur_fall[i*CW +: CW]) - 2) ? 1'b1 : 1'b0;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int budget;
    int d0;
    modelReset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_charge_out", 64'(charge_out), 64'd0);
    checkOutput("rst_touched", 64'(touched), 64'd0);
    checkOutput("rst_press", 64'(press_event), 64'd0);
    checkOutput("rst_raw", 64'(raw_count), 64'd0);
    checkOutput("rst_scan_done", 64'(scan_done), 64'd0);
    checkOutput("rst_calibrating", 64'(calibrating), 64'd0);
    checkOutput("rst_cal_done", 64'(cal_done), 64'd0);
    reset = 1'b1;

    // Uncalibrated: near-timeout counts must not register as touches.
    repeat (5) applyStimulus(199, 199, 199);
    runScans();
    checkOutput("uncal_touched", 64'(touched), 64'd0);

    requestCal();
    repeat (4) applyStimulus(20, 30, 40);
    runScans();
    checkOutput("cal_touched", 64'(touched), 64'd0);
    checkOutput("cal_flag_clear", 64'(calibrating), 64'd0);

    applyStimulus(20, 50, 40);
    applyStimulus(20, 30, 40);
    applyStimulus(20, 40, 40);
    applyStimulus(20, 50, 50);
    applyStimulus(20, 50, 50);
    runScans();
    checkOutput("touch_ch1", 64'(touched), 64'h2);

    applyStimulus(20, 50, 0);
    applyStimulus(20, 50, 0);
    runScans();
    checkOutput("touch_ch2", 64'(touched), 64'h6);
    checkOutput("raw_ch2_timeout", 64'(raw_count[2*CW +: CW]), 64'(TO));

    // Reset in the middle of a calibration scan's measure phase.
    requestCal();
    stim_q.push_back({8'd100, 8'd100, 8'd100});
    enable = 1'b1;
    budget = 0;
    while (charge_out !== 1'b1 && budget < 1000) begin
      @(posedge clock); #1;
      budget++;
    end
    while (!(charge_out === 1'b0 && k >= 10) && budget < 1000) begin
      @(posedge clock); #1;
      budget++;
    end
    if (budget >= 1000) checkOutput("wait_measure_timeout", 64'(budget), 64'd0);
    enable = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("mid_rst_charge_out", 64'(charge_out), 64'd0);
    checkOutput("mid_rst_touched", 64'(touched), 64'd0);
    checkOutput("mid_rst_press", 64'(press_event), 64'd0);
    checkOutput("mid_rst_raw", 64'(raw_count), 64'd0);
    checkOutput("mid_rst_scan_done", 64'(scan_done), 64'd0);
    checkOutput("mid_rst_calibrating", 64'(calibrating), 64'd0);
    checkOutput("mid_rst_cal_done", 64'(cal_done), 64'd0);
    reset = 1'b1;
    modelReset();
    d0 = done_cnt;
    repeat (30) @(posedge clock);
    #1;
    checkOutput("mid_rst_no_scan_done", 64'(done_cnt - d0), 64'd0);

    // Baselines are back to all-ones after reset.
    repeat (5) applyStimulus(199, 199, 199);
    runScans();
    checkOutput("post_rst_touched", 64'(touched), 64'd0);

    // Single scan with enable dropped during charge.
    d0 = done_cnt;
    applyStimulus(20, 30, 40);
    runScans();
    repeat (20) @(posedge clock);
    #1;
    checkOutput("single_scan_done_cnt", 64'(done_cnt - d0), 64'd1);
    checkOutput("idle_charge_out", 64'(charge_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cap_sensor_scanner.md
CAP_SENSOR_SCANNER -- requirements
Module: cap_sensor_scanner

Interface
REQ-001 SHALL have parameter NUM_SENSORS, default 9, number of capacitive channels.
REQ-002 SHALL have parameter CNT_W, default 16, width of the discharge counter and of each raw count.
REQ-003 SHALL have parameter CHARGE_CYCLES, default 64, number of cycles charge_out is held high per scan.
REQ-004 SHALL have parameter TIMEOUT, default 4095, maximum measure count (must be < 2^CNT_W).
REQ-005 SHALL have parameter DEBOUNCE, default 3, number of consecutive agreeing scans needed to change a touched bit.
REQ-006 SHALL have parameter CAL_SCANS, default 8, number of calibration scans averaged (power of two).
REQ-007 SHALL have parameter MARGIN, default 32, count added to the baseline to form the threshold.
REQ-008 SHALL have port clock, in, 1: single clock; every flop is rising-edge.
REQ-009 SHALL have port reset, in, 1: synchronous, active-low reset.
REQ-010 SHALL have port enable, in, 1: allows new scans to start.
REQ-011 SHALL have port cal_start, in, 1: single-cycle request to recalibrate baselines.
REQ-012 SHALL have port sense_in, in, NUM_SENSORS: asynchronous sensor pins.
REQ-013 SHALL have port charge_out, out, 1: shared charge drive.
REQ-014 SHALL have port touched, out, NUM_SENSORS: debounced touch state.
REQ-015 SHALL have port press_event, out, NUM_SENSORS: one-cycle pulse on each touched 0->1 transition.
REQ-016 SHALL have port raw_count, out, NUM_SENSORS*CNT_W: last measured counts, with channel i at bits [i*CNT_W +: CNT_W].
REQ-017 SHALL have the following 1-bit outputs:
- scan_done: one-cycle pulse per completed scan.
- calibrating: high during calibration.
- cal_done: one-cycle pulse at the end of calibration.

Function
REQ-018 SHALL pass sense_in through a two-flop synchroniser per channel before any use.
REQ-019 SHALL implement the FSM IDLE -> CHARGE -> MEASURE -> EVAL, as follows:
- IDLE -> CHARGE when enable=1.
- EVAL -> CHARGE when enable=1; EVAL -> IDLE otherwise.
REQ-020 SHALL drive charge_out=1 only in CHARGE and hold CHARGE for exactly CHARGE_CYCLES cycles.
REQ-021 SHALL clear the measure counter to 0 on MEASURE entry and increment it by 1 each MEASURE cycle.
REQ-022 SHALL latch a channel's count on the first MEASURE cycle in which its synchronised input is 0; later transitions SHALL be ignored.
REQ-023 SHALL leave MEASURE when every channel has latched or the counter equals TIMEOUT; unlatched channels SHALL record TIMEOUT.
REQ-024 SHALL, in EVAL (one cycle), compute raw_hit[i] = count[i] > threshold[i], where threshold[i] = baseline[i] + MARGIN saturated at 2^CNT_W-1.
REQ-025 SHALL keep a per-channel debounce counter:
- Reset the counter when raw_hit equals touched.
- Otherwise increment it; on reaching DEBOUNCE, toggle touched and clear the counter.
REQ-026 SHALL register touched, press_event, raw_count and scan_done in EVAL, so they are visible the cycle after EVAL.
REQ-027 SHALL, on cal_start, enter calibration at the next CHARGE entry; cal_start while calibrating SHALL be ignored.
REQ-028 SHALL, while calibrating, do all of the following:
- Accumulate each count into a (CNT_W+log2(CAL_SCANS))-bit sum.
- Hold touched/debounce unchanged and suppress press_event.
REQ-029 SHALL, after CAL_SCANS scans, set baseline[i] = sum[i] >> log2(CAL_SCANS), clear calibrating, and pulse cal_done alongside that scan's scan_done.
REQ-030 SHALL finish an in-progress scan when enable falls mid-scan, then go to IDLE.

Reset
REQ-031 SHALL, on reset=0 at a clock edge, set all of the following regardless of state:
- FSM to IDLE.
- charge_out, touched, press_event, scan_done, calibrating, cal_done and raw_count to 0.
- Debounce counters and sums to 0.
- Baselines to all-ones, so that no touch is possible before calibration.

Structure
REQ-032 SHALL place the FSM state encoding and the default parameter constants in shared package whackamole_pkg.
REQ-033 SHALL instantiate one sub-module, cap_channel_debounce, once per channel, containing that channel's latch, threshold compare and debounce counter.

Verification (NUM_SENSORS=3, CNT_W=8, CHARGE_CYCLES=4, TIMEOUT=200, DEBOUNCE=2, CAL_SCANS=4, MARGIN=10)
REQ-034 SHALL verify that reset is asserted mid-MEASURE -> next cycle charge_out=0, all outputs 0, no scan_done.
REQ-035 SHALL verify that cal_start with channels falling at counts 20/30/40 for 4 scans -> cal_done with the 4th scan_done, baselines 20/30/40, touched=000.
REQ-036 SHALL verify the following after calibration:
- Channel 1 at count 50 for two scans -> touched=010 and press_event=010 pulse after the second scan_done.
- A single 50-count scan -> no change.
REQ-037 SHALL verify that channel 2 never falling -> raw_count[2]=200, MEASURE lasts 201 cycles, touched[2]=1 after 2 scans.
REQ-038 SHALL verify that, without calibration, all channels at count 199 -> touched stays 000 for 5 scans.
REQ-039 SHALL verify that enable is dropped during CHARGE -> the scan completes with exactly one scan_done, then IDLE with charge_out=0.
